intr_claim_ctrl: RTL and testbench

- Interrupt controller in the slow (CPU) clock domain, fed by the outputs of the fast-to-slow rising-edge interrupt synchronizers.
- Edge-detects each source, latches it as pending, and applies a per-source enable mask.
- Raises a single `irq` to the CPU.
- Arbitrates pending sources through a claim/complete handshake with fixed priority; index 0 is highest.

---
 rtl/intr_claim_ctrl.sv | 118 +++++++++++
 tb/tb_intr_claim_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_claim_ctrl.sv
// Slow-domain interrupt controller: per-source edge detect, pending latch and enable mask,
// single irq, and a fixed-priority claim/complete handshake (index 0 is highest).
module intr_claim_ctrl #(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [INTR_WIDTH-1:0] intr_in,
    input  logic                  en_wr,
    input  logic [INTR_WIDTH-1:0] en_wdata,
    output logic [INTR_WIDTH-1:0] enable,
    output logic [INTR_WIDTH-1:0] pending,
    output logic                  irq,
    output logic                  claim_ready,
    input  logic                  claim_req,
    output logic                  claim_ack,
    output logic                  claim_hit,
    output logic [ID_WIDTH-1:0]   claim_id,
    input  logic                  complete_valid,
    input  logic [ID_WIDTH-1:0]   complete_id
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                state_q, state_d;
    logic [INTR_WIDTH-1:0] intr_prev;
    logic [INTR_WIDTH-1:0] inflight;
    logic [INTR_WIDTH-1:0] rise;
    logic [INTR_WIDTH-1:0] eligible;
    logic [INTR_WIDTH-1:0] sel_mask;
    logic [INTR_WIDTH-1:0] complete_mask;
    logic [INTR_WIDTH-1:0] pending_d;
    logic [INTR_WIDTH-1:0] inflight_d;
    logic                  sel_found;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  claim_fire;
    logic                  claim_take;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rise          = intr_in & ~intr_prev;
        eligible      = pending & enable;
        sel_found     = 1'b0;
        sel_id        = '0;
        sel_mask      = '0;
        complete_mask = '0;

        // Scan from the top down so the lowest eligible index is the one left selected.
        for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_id    = ID_WIDTH'(i);
                sel_mask  = '0;
                sel_mask[i] = 1'b1;
            end
        end

        // Out-of-range IDs match no bit and therefore have no effect.
        for (int i = 0; i < INTR_WIDTH; i++) begin
            if (complete_valid && complete_id == ID_WIDTH'(i)) begin
                complete_mask[i] = 1'b1;
            end
        end

        claim_fire = (state_q == IDLE) && claim_req;
        claim_take = claim_fire && sel_found;

        // Gateway uses start-of-cycle inflight, so a rise coinciding with its completion is dropped.
        pending_d  = pending | (rise & ~inflight);
        inflight_d = inflight & ~complete_mask;
        if (claim_take) begin
            pending_d  = pending_d & ~sel_mask;
            inflight_d = inflight_d | sel_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (claim_req) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign claim_ready = (state_q == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            intr_prev <= '0;
            pending   <= '0;
            inflight  <= '0;
            enable    <= '0;
            irq       <= 1'b0;
            claim_ack <= 1'b0;
            claim_hit <= 1'b0;
            claim_id  <= '0;
        end else begin
            state_q   <= state_d;
            intr_prev <= intr_in;
            pending   <= pending_d;
            inflight  <= inflight_d;
            irq       <= |(pending & enable);
            claim_ack <= claim_fire;
            if (en_wr) begin
                enable <= en_wdata;
            end
            if (claim_fire) begin
                claim_hit <= sel_found;
                claim_id  <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_intr_claim_ctrl.sv
// Directed bench for intr_claim_ctrl: an 8-source instance for the main flow and a
// 6-source instance for out-of-range completion IDs.
module tb_intr_claim_ctrl;

    logic       clk = 1'b0;
    logic       resetn;

    logic [7:0] intr_in, en_wdata, enable, pending;
    logic       en_wr, irq, claim_ready, claim_req, claim_ack, claim_hit, complete_valid;
    logic [2:0] claim_id, complete_id;

    logic [5:0] intr6, en_wdata6, enable6, pending6;
    logic       en_wr6, irq6, claim_ready6, claim_req6, claim_ack6, claim_hit6, complete_valid6;
    logic [2:0] claim_id6, complete_id6;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    intr_claim_ctrl #(.INTR_WIDTH(8), .ID_WIDTH(3)) u_dut (
        .clk(clk), .resetn(resetn), .intr_in(intr_in), .en_wr(en_wr), .en_wdata(en_wdata),
        .enable(enable), .pending(pending), .irq(irq), .claim_ready(claim_ready),
        .claim_req(claim_req), .claim_ack(claim_ack), .claim_hit(claim_hit), .claim_id(claim_id),
        .complete_valid(complete_valid), .complete_id(complete_id)
    );

    intr_claim_ctrl #(.INTR_WIDTH(6), .ID_WIDTH(3)) u_dut6 (
        .clk(clk), .resetn(resetn), .intr_in(intr6), .en_wr(en_wr6), .en_wdata(en_wdata6),
        .enable(enable6), .pending(pending6), .irq(irq6), .claim_ready(claim_ready6),
        .claim_req(claim_req6), .claim_ack(claim_ack6), .claim_hit(claim_hit6), .claim_id(claim_id6),
        .complete_valid(complete_valid6), .complete_id(complete_id6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic complete8(input logic [2:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        tick();
        complete_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        intr_in = 8'h01; en_wr = 1'b0; en_wdata = '0; claim_req = 1'b0;
        complete_valid = 1'b0; complete_id = '0;
        intr6 = '0; en_wr6 = 1'b0; en_wdata6 = '0; claim_req6 = 1'b0;
        complete_valid6 = 1'b0; complete_id6 = '0;

        // 1. Reset state, then release with intr_in[0] held high.
        tick(2);
        check("rst_pending", pending, 8'h00);
        check("rst_enable", enable, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_ack", claim_ack, 1'b0);
        check("rst_ready", claim_ready, 1'b1);
        resetn = 1'b1;
        tick();
        check("t1_pending_after_release", pending, 8'h01);
        tick();
        check("t1_irq_masked", irq, 1'b0);
        en_wr = 1'b1; en_wdata = 8'hFF;
        tick();
        en_wr = 1'b0;
        check("t1_enable_written", enable, 8'hFF);
        check("t1_irq_still_low", irq, 1'b0);
        tick();
        check("t1_irq_high", irq, 1'b1);

        // Drain source 0 so later steps start clean.
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("t1_claim_id0", {claim_ack, claim_hit, 5'(claim_id)}, {1'b1, 1'b1, 5'd0});
        intr_in = 8'h00;
        tick();
        complete8(3'd0);
        tick();
        check("t1_irq_cleared", irq, 1'b0);

        // 2. Sources 5 and 2 together; priority picks 2 first.
        intr_in = 8'h24;
        tick();
        intr_in = 8'h00;
        check("t2_pending_both", pending, 8'h24);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("t2_claim_first", {claim_ack, claim_hit, 5'(claim_id)}, {1'b1, 1'b1, 5'd2});
        check("t2_pending_after_first", pending, 8'h20);
        check("t2_ready_in_resp", claim_ready, 1'b0);
        tick();
        check("t2_ack_drops_id_holds", {claim_ack, 5'(claim_id)}, {1'b0, 5'd2});
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("t2_claim_second", {claim_ack, claim_hit, 5'(claim_id)}, {1'b1, 1'b1, 5'd5});
        check("t2_pending_empty", pending, 8'h00);
        check("t2_irq_lags", irq, 1'b1);
        tick();
        check("t2_irq_drops", irq, 1'b0);
        complete8(3'd2);
        complete8(3'd5);

        // 3. Rises on an in-flight source are dropped until it completes.
        intr_in = 8'h08;
        tick();
        intr_in = 8'h00;
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("t3_claim_id3", {claim_hit, 5'(claim_id)}, {1'b1, 5'd3});
        tick();
        intr_in = 8'h08; tick();
        intr_in = 8'h00; tick();
        intr_in = 8'h08; tick();
        intr_in = 8'h00; tick();
        check("t3_inflight_drops", pending, 8'h00);
        complete8(3'd3);
        intr_in = 8'h08;
        tick();
        intr_in = 8'h00;
        check("t3_reopened", pending, 8'h08);
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        tick();
        complete8(3'd3);

        // 4. Empty claim, with claim_req held through RESP.
        claim_req = 1'b1;
        tick();
        check("t4_empty_claim", {claim_ack, claim_hit, 5'(claim_id)}, {1'b1, 1'b0, 5'd0});
        tick();
        claim_req = 1'b0;
        check("t4_no_ack_in_resp", claim_ack, 1'b0);
        tick();
        check("t4_still_no_ack", claim_ack, 1'b0);

        // Rise merged into the claim that selects the same source.
        intr_in = 8'h10;
        tick();
        intr_in = 8'h00;
        tick();
        intr_in = 8'h10; claim_req = 1'b1;
        tick();
        intr_in = 8'h00; claim_req = 1'b0;
        check("m_merge_claim", {claim_hit, 5'(claim_id)}, {1'b1, 5'd4});
        check("m_merge_pending", pending, 8'h00);
        tick();
        complete8(3'd4);

        // Masking keeps pending latched; selection uses the pre-write mask.
        en_wr = 1'b1; en_wdata = 8'h00; intr_in = 8'h02;
        tick();
        en_wr = 1'b0; intr_in = 8'h00;
        check("k_masked_pending", pending, 8'h02);
        en_wr = 1'b1; en_wdata = 8'hFF; claim_req = 1'b1;
        tick();
        en_wr = 1'b0; claim_req = 1'b0;
        check("k_old_mask_used", {claim_ack, claim_hit}, {1'b1, 1'b0});
        check("k_pending_kept", pending, 8'h02);
        tick();
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        check("k_reenabled_claim", {claim_hit, 5'(claim_id)}, {1'b1, 5'd1});
        tick();

        // 5b. Complete of 1 and rise of 1 in the same cycle: rise dropped.
        intr_in = 8'h02; complete_valid = 1'b1; complete_id = 3'd1;
        tick();
        complete_valid = 1'b0; intr_in = 8'h00;
        check("c_complete_rise_same", pending, 8'h00);
        tick();
        intr_in = 8'h02;
        tick();
        intr_in = 8'h00;
        check("c_after_complete", pending, 8'h02);

        // Claim and complete of the same source in one cycle: claim wins.
        claim_req = 1'b1;
        tick();
        claim_req = 1'b0;
        tick();
        intr_in = 8'h02; tick();
        intr_in = 8'h00; tick();
        complete8(3'd1);
        check("c_reclaim_setup", pending, 8'h00);
        intr_in = 8'h02; tick();
        intr_in = 8'h00;
        claim_req = 1'b1; complete_valid = 1'b1; complete_id = 3'd1;
        tick();
        claim_req = 1'b0; complete_valid = 1'b0;
        // Source 1 is pending again and not in flight: claim it, then complete it while reclaiming.
        tick();
        intr_in = 8'h02; tick();
        intr_in = 8'h00;
        check("c_claim_wins", pending, 8'h00);

        // 5a. Out-of-range completion ID on a 6-source instance.
        en_wr6 = 1'b1; en_wdata6 = 6'h3F; intr6 = 6'h01;
        tick();
        en_wr6 = 1'b0; intr6 = 6'h00;
        claim_req6 = 1'b1;
        tick();
        claim_req6 = 1'b0;
        check("w6_claim_id0", {claim_hit6, 5'(claim_id6)}, {1'b1, 5'd0});
        complete_valid6 = 1'b1; complete_id6 = 3'd7;
        tick();
        complete_valid6 = 1'b0;
        intr6 = 6'h01; tick();
        intr6 = 6'h00;
        check("w6_bad_id_ignored", pending6, 6'h00);
        check("w6_enable_kept", enable6, 6'h3F);
        complete_valid6 = 1'b1; complete_id6 = 3'd0;
        tick();
        complete_valid6 = 1'b0;
        intr6 = 6'h01; tick();
        intr6 = 6'h00;
        check("w6_good_id", pending6, 6'h01);

        // 5c. Reset asserted before the claim response edge.
        intr_in = 8'h40; tick();
        intr_in = 8'h00;
        check("r_setup_pending", pending[6], 1'b1);
        claim_req = 1'b1;
        #3;
        resetn = 1'b0;
        tick();
        claim_req = 1'b0;
        check("r_no_ack", claim_ack, 1'b0);
        check("r_outputs_zero", {pending, enable, irq, claim_hit, claim_id},
              {8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
        check("r_ready", claim_ready, 1'b1);
        resetn = 1'b1;
        tick(2);
        check("r_no_late_ack", claim_ack, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
